// File: rtl/port_io_pkg.sv
// ---------------------------------------------------------------------------
// port_io_pkg
//
// Shared definitions for the memory-mapped port blocks on the 8-bit CPU
// address bus: register addresses of the input and output ports, the bit
// positions inside the input-port status register, and the read-address
// decoder used by the input-port block.
// ---------------------------------------------------------------------------
package port_io_pkg;

    // Input-port block (read side)
    localparam logic [7:0] PORT_IN_00_ADDR   = 8'hF0;
    localparam logic [7:0] PORT_IN_01_ADDR   = 8'hF1;
    localparam logic [7:0] PORT_IN_STAT_ADDR = 8'hF2;

    // Output-port block (write side), kept here so both blocks share one map
    localparam logic [7:0] PORT_OUT_00_ADDR  = 8'hE0;
    localparam logic [7:0] PORT_OUT_01_ADDR  = 8'hE1;

    // Status register bit positions
    localparam int CHG00_BIT = 0;
    localparam int CHG01_BIT = 1;

    // Which register a read address selects
    typedef enum logic [1:0] {
        RD_SEL_NONE = 2'd0,
        RD_SEL_P00  = 2'd1,
        RD_SEL_P01  = 2'd2,
        RD_SEL_STAT = 2'd3
    } rd_sel_e;

    function automatic rd_sel_e decode_rd_addr(input logic [7:0] addr);
        rd_sel_e sel;
        sel = RD_SEL_NONE;
        case (addr)
            PORT_IN_00_ADDR:   sel = RD_SEL_P00;
            PORT_IN_01_ADDR:   sel = RD_SEL_P01;
            PORT_IN_STAT_ADDR: sel = RD_SEL_STAT;
            default:           sel = RD_SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/port_in_channel.sv
// ---------------------------------------------------------------------------
// port_in_channel
//
// One external input port brought into the clk domain: a two-flop
// synchronizer, an optional debounce filter, and change detection on the
// accepted ("stable") value.
//
// Build option: PORT_IN_DEBOUNCE_EN
//   undefined : stable <= sync2 every cycle (pin-to-stable = 2 edges after
//               the sampling edge).
//   defined   : a candidate register plus a saturating stability counter;
//               stable only takes the candidate once it has been seen for
//               DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   port_in  in   DATA_W-bit pin value, asynchronous to clk
//   stable   out  accepted port value
//   changed  out  one-cycle pulse: stable differs from its previous value
// ---------------------------------------------------------------------------
module port_in_channel
    import port_io_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] port_in,
    output logic [DATA_W-1:0] stable,
    output logic              changed
);

    logic [DATA_W-1:0] sync1;
    logic [DATA_W-1:0] sync2;
    logic [DATA_W-1:0] stable_q;
    logic [DATA_W-1:0] stable_prev;

    // A zero-cycle filter would accept every value immediately and the
    // counter width below would collapse; refuse such a build outright.
    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
        $error("port_in_channel: DEBOUNCE_CYCLES must be at least 1");
    end

    // ---- synchronizer: pin -> sync1 -> sync2 ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= port_in;
            sync2 <= sync1;
        end
    end

`ifdef PORT_IN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [DATA_W-1:0] candidate;
    logic [CNT_W-1:0]  stab_cnt;

    // ---- debounce: candidate tracks sync2, counter measures how long ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            candidate <= '0;
            stab_cnt  <= '0;
            stable_q  <= '0;
        end else begin
            if (sync2 != candidate) begin
                candidate <= sync2;
                stab_cnt  <= '0;
            end else if (stab_cnt != CNT_MAX) begin
                stab_cnt  <= stab_cnt + 1'b1;
            end
            // The candidate has been held long enough; re-loading the same
            // value every cycle while saturated is harmless.
            if (stab_cnt == CNT_MAX) begin
                stable_q <= candidate;
            end
        end
    end
`else
    // ---- stable stage: straight register after the synchronizer ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q <= '0;
        end else begin
            stable_q <= sync2;
        end
    end
`endif

    // ---- change detect: compare against the previous-cycle stable ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_prev <= '0;
        end else begin
            stable_prev <= stable_q;
        end
    end

    // Both operands are registers, so the pulse is glitch-free and lasts
    // exactly the one cycle after stable moves. Because stable_prev resets
    // to zero, a nonzero pin at reset release also produces a pulse.
    assign changed = (stable_q != stable_prev);
    assign stable  = stable_q;

endmodule

// File: rtl/port_inputs.sv
// ---------------------------------------------------------------------------
// port_inputs
//
// Memory-mapped input-port block, the read-side counterpart of the output
// ports at 0xE0/0xE1. Two asynchronous 8-bit pin groups are synchronized
// (and optionally debounced) by port_in_channel instances; this level owns
// the sticky change flags, the read mux and the interrupt.
//
//   0xF0  read  stable value of port_in_00
//   0xF1  read  stable value of port_in_01
//   0xF2  read  {6'b0, chg01, chg00}; reading clears both flags
//
// Build option: PORT_IN_DEBOUNCE_EN enables the debounce filter inside each
// channel (DEBOUNCE_CYCLES consecutive stable cycles before acceptance).
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   re          in   CPU read strobe (one cycle)
//   address     in   CPU address [7:0]
//   port_in_00  in   external port 0 pins, asynchronous
//   port_in_01  in   external port 1 pins, asynchronous
//   data_out    out  registered read data, holds between mapped reads
//   data_valid  out  one-cycle pulse the cycle after a mapped read
//   irq         out  high while either change flag is pending
// ---------------------------------------------------------------------------
module port_inputs
    import port_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       re,
    input  logic [7:0] address,
    input  logic [7:0] port_in_00,
    input  logic [7:0] port_in_01,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       irq
);

    logic [7:0] stable00;
    logic [7:0] stable01;
    logic       changed00;
    logic       changed01;
    logic       chg00;
    logic       chg01;
    logic [7:0] status;
    rd_sel_e    rd_sel;

    // ---- per-port synchronize / debounce / change detect ----
    port_in_channel #(
        .DATA_W          (8),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch00 (
        .clk     (clk),
        .reset   (reset),
        .port_in (port_in_00),
        .stable  (stable00),
        .changed (changed00)
    );

    port_in_channel #(
        .DATA_W          (8),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch01 (
        .clk     (clk),
        .reset   (reset),
        .port_in (port_in_01),
        .stable  (stable01),
        .changed (changed01)
    );

    always_comb begin
        status            = '0;
        status[CHG00_BIT] = chg00;
        status[CHG01_BIT] = chg01;
    end

    assign rd_sel = re ? decode_rd_addr(address) : RD_SEL_NONE;

    // ---- read response and flag register stage ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            chg00      <= 1'b0;
            chg01      <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            chg00      <= chg00 | changed00;
            chg01      <= chg01 | changed01;
            case (rd_sel)
                RD_SEL_P00: begin
                    data_out   <= stable00;
                    data_valid <= 1'b1;
                end
                RD_SEL_P01: begin
                    data_out   <= stable01;
                    data_valid <= 1'b1;
                end
                RD_SEL_STAT: begin
                    // Report the flags as they stand before this edge, then
                    // clear them -- unless a change lands on this very edge,
                    // in which case the new event must not be lost.
                    data_out   <= status;
                    data_valid <= 1'b1;
                    chg00      <= changed00;
                    chg01      <= changed01;
                end
                default: begin
                    // unmapped or idle: data_out holds
                end
            endcase
        end
    end

    assign irq = chg00 | chg01;

endmodule

// File: tb/tb_port_inputs.sv
// ---------------------------------------------------------------------------
// tb_port_inputs
//
// Directed bench for port_inputs. Expected read data is queued when a read
// is issued and popped when the DUT raises data_valid. Built with
// PORT_IN_DEBOUNCE_EN it exercises the debounce filter (DEBOUNCE_CYCLES=4);
// otherwise it runs the plain synchronizer sequences.
// ---------------------------------------------------------------------------
module tb_port_inputs;
    import port_io_pkg::*;

    logic       clk;
    logic       reset;
    logic       re;
    logic [7:0] address;
    logic [7:0] port_in_00;
    logic [7:0] port_in_01;
    logic [7:0] data_out;
    logic       data_valid;
    logic       irq;

    int unsigned cmp_cnt  = 0;
    int unsigned fail_cnt = 0;

    logic [7:0] exp_q[$];
    logic       exp_vld;
    logic [7:0] last_data;

    port_inputs #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .re         (re),
        .address    (address),
        .port_in_00 (port_in_00),
        .port_in_01 (port_in_01),
        .data_out   (data_out),
        .data_valid (data_valid),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        cmp_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
        end
    endtask

    // One clock edge, then inspect outputs 1 time unit later.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        check("data_valid", {7'b0, data_valid}, {7'b0, exp_vld});
        if (data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", {7'b0, data_valid}, 8'h00);
            end else begin
                e = exp_q.pop_front();
                last_data = e;
                check("read_data", data_out, e);
            end
        end else if (exp_vld && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] expv);
        re      = 1'b1;
        address = a;
        exp_q.push_back(expv);
        exp_vld = 1'b1;
        tick();
        re      = 1'b0;
        exp_vld = 1'b0;
    endtask

    task automatic rd_unmapped(input logic [7:0] a);
        re      = 1'b1;
        address = a;
        exp_vld = 1'b0;
        tick();
        check("unmapped_hold", data_out, last_data);
        re      = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        re         = 1'b0;
        address    = 8'h00;
        port_in_00 = 8'hA5;
        port_in_01 = 8'h3C;
        exp_vld    = 1'b0;
        last_data  = 8'h00;

        // Reset state
        ticks(3);
        check("rst_data_out", data_out, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);

`ifdef PORT_IN_DEBOUNCE_EN
        // Debounce build: start from quiet pins
        port_in_00 = 8'h00;
        port_in_01 = 8'h00;
        ticks(2);
        reset = 1'b1;
        ticks(10);
        check("db_irq_idle", {7'b0, irq}, 8'h00);
        rd(PORT_IN_00_ADDR, 8'h00);

        // 3-cycle glitch must be filtered
        port_in_00 = 8'hFF;
        ticks(3);
        port_in_00 = 8'h00;
        ticks(12);
        check("db_glitch_irq", {7'b0, irq}, 8'h00);
        rd(PORT_IN_00_ADDR, 8'h00);
        rd(PORT_IN_STAT_ADDR, 8'h00);

        // Held edge: stable after 7 edges, flag one edge later
        port_in_00 = 8'hFF;
        ticks(7);
        check("db_irq_before", {7'b0, irq}, 8'h00);
        rd(PORT_IN_00_ADDR, 8'h00);
        check("db_irq_not_yet", {7'b0, irq}, 8'h00);
        rd(PORT_IN_00_ADDR, 8'hFF);
        check("db_irq_set", {7'b0, irq}, 8'h01);
        rd(PORT_IN_STAT_ADDR, 8'h01);
        check("db_irq_clr", {7'b0, irq}, 8'h00);
`else
        // 1: release with nonzero pins
        reset = 1'b1;
        ticks(4);
        check("t1_irq_set", {7'b0, irq}, 8'h01);
        rd(PORT_IN_00_ADDR, 8'hA5);
        rd(PORT_IN_01_ADDR, 8'h3C);
        check("t1_irq_still", {7'b0, irq}, 8'h01);
        rd(PORT_IN_STAT_ADDR, 8'h03);
        check("t1_irq_clr", {7'b0, irq}, 8'h00);
        rd(PORT_IN_STAT_ADDR, 8'h00);

        // 2: single change on port 0
        port_in_00 = 8'h5A;
        ticks(3);
        check("t2_irq_early", {7'b0, irq}, 8'h00);
        tick();
        check("t2_irq_set", {7'b0, irq}, 8'h01);
        rd(PORT_IN_00_ADDR, 8'h5A);
        rd(PORT_IN_STAT_ADDR, 8'h01);
        check("t2_irq_clr", {7'b0, irq}, 8'h00);

        // 3: status read on the edge a new flag sets
        port_in_01 = 8'h77;
        ticks(3);
        rd(PORT_IN_STAT_ADDR, 8'h00);
        check("t3_irq_kept", {7'b0, irq}, 8'h01);
        rd(PORT_IN_STAT_ADDR, 8'h02);
        check("t3_irq_clr", {7'b0, irq}, 8'h00);

        // 4: unmapped read holds, back-to-back reads
        rd(PORT_IN_00_ADDR, 8'h5A);
        rd_unmapped(8'h7F);
        rd(PORT_IN_00_ADDR, 8'h5A);
        rd(PORT_IN_01_ADDR, 8'h77);
        tick();

        // 5: reset while a read result is on the outputs
        port_in_00 = 8'h11;
        ticks(4);
        check("t5_irq_pre", {7'b0, irq}, 8'h01);
        rd(PORT_IN_01_ADDR, 8'h77);
        reset = 1'b0;
        #1;
        check("t5_rst_valid", {7'b0, data_valid}, 8'h00);
        check("t5_rst_data", data_out, 8'h00);
        check("t5_rst_irq", {7'b0, irq}, 8'h00);
        last_data = 8'h00;
        ticks(2);
        reset = 1'b1;
        ticks(4);
        check("t5_data_hold", data_out, 8'h00);
        check("t5_irq_again", {7'b0, irq}, 8'h01);
        rd(PORT_IN_STAT_ADDR, 8'h03);
        rd(PORT_IN_00_ADDR, 8'h11);
`endif

        check("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/port_inputs.md
Name: port_inputs

Overview:
- Memory-mapped input-port block; the read-side counterpart of the output-port block at 0xE0/0xE1.
- Samples two asynchronous 8-bit external input ports into the clk domain.
- Latches a per-port change flag and answers CPU reads at 0xF0/0xF1 (port data) and 0xF2 (status) with one-cycle latency.
- Sits on the same 8-bit address bus as the memory and output ports; raises irq while any change flag is pending.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive cycles a synchronized value must stay stable before it is accepted (used only with DEBOUNCE_EN); counter width = $clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- re  input  1  read enable from CPU, one-cycle strobe.
- address  input  8  CPU address.
- port_in_00  input  8  external input port 0, asynchronous to clk.
- port_in_01  input  8  external input port 1, asynchronous to clk.
- data_out  output  8  registered read data.
- data_valid  output  1  one-cycle pulse: data_out carries a mapped read result.
- irq  output  1  high while chg00 or chg01 is set.

Behaviour:
- Reset (reset low, async): sync stages, stable values, flags, data_out and data_valid all go to 0. irq is therefore 0.
- Per port, the input passes through a 2-flop synchronizer (sync1 -> sync2). Without debounce, stable <= sync2 each cycle.
- Pin-to-stable latency: a pin change sampled at edge N appears in stable after edge N+2.
- Change detect: chg flag <= 1 at the edge after stable differs from its previous-cycle value. The flag is sticky.
- Address map, read with re=1 at edge M:
  - 0xF0 -> data_out <= stable00.
  - 0xF1 -> data_out <= stable01.
  - 0xF2 -> data_out <= {6'b0, chg01, chg00}; both flags clear at the same edge.
  - In all three cases, data_valid <= 1 at edge M, high for exactly one cycle.
- Read latency: data_out and data_valid are valid in the cycle after the re strobe. data_out holds its value between mapped reads.
- Unmapped address or re=0: data_valid <= 0, data_out holds, flags untouched.
- Simultaneous flag set and status-read clear on the same edge: set wins, flag stays 1. data_out reports the pre-edge flag value.
- Back-to-back reads on consecutive cycles are each served, giving consecutive data_valid pulses.
- Reset release with nonzero pins: stable moves 0 -> pin value, so chg flags set and irq asserts. Firmware clears this by reading 0xF2.
- Reset mid-operation: all state clears immediately. A read in flight is dropped (no data_valid).
- irq is a registered function of the flags only: irq = chg00 | chg01.

Optional Feature:
- Macro PORT_IN_DEBOUNCE_EN.
- Defined: each port has a counter. It reloads to 0 whenever sync2 differs from a candidate register (candidate <= sync2). Otherwise it increments, saturating at DEBOUNCE_CYCLES. stable <= candidate only when the count reaches DEBOUNCE_CYCLES.
  - Latency: 3 + DEBOUNCE_CYCLES cycles from pin to stable for a clean edge.
  - Glitches shorter than DEBOUNCE_CYCLES never reach stable and never set a flag.
- Undefined: no counter or candidate logic; stable follows sync2 with one register stage, as above.

Decomposition:
- Package port_io_pkg holds:
  - PORT_IN_00_ADDR = 8'hF0, PORT_IN_01_ADDR = 8'hF1, PORT_IN_STAT_ADDR = 8'hF2.
  - PORT_OUT_00_ADDR = 8'hE0, PORT_OUT_01_ADDR = 8'hE1.
  - Status bit indices CHG00_BIT = 0, CHG01_BIT = 1.
- Sub-module port_in_channel: synchronizer, optional debounce and change detect for one 8-bit port.
  - Outputs stable[7:0] and a one-cycle changed pulse.
  - Instantiated twice. The top level owns the flags, read mux, data_out, data_valid and irq.

Test Plan:
1. Reset low with pins 0xA5/0x3C, then release, wait 4 cycles -> read 0xF0 gives 0xA5, read 0xF1 gives 0x3C, data_valid pulses once each, irq=1. Read 0xF2 -> 0x03; next cycle irq=0 and a second 0xF2 read returns 0x00.
2. After clearing, set port_in_00 = 0x5A at edge N -> stable00 = 0x5A after N+2, chg00 and irq after N+3. Read 0xF2 -> 0x01.
3. Read 0xF2 on the same edge a new port_in_01 change sets chg01 -> data_out shows the old flags with chg01=0; chg01 remains 1 afterwards and irq stays high.
4. Read unmapped 0x7F between reads of 0xF0 -> data_valid stays 0 and data_out holds the prior 0xF0 value. Back-to-back re on 0xF0, 0xF1 -> two consecutive data_valid pulses with the correct data.
5. Drive reset low one cycle after re to 0xF1 -> data_out=0x00, data_valid=0, flags=0, no late pulse after release.
6. With PORT_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES=4:
   - A 3-cycle glitch 0x00->0xFF->0x00 -> stable unchanged, no flag.
   - A held 0xFF -> stable = 0xFF at 7 cycles after the pin edge, chg flag set on the following edge.
